phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter FILL_SECS, default 300, sets the FILL phase duration in seconds (10 bits).
REQ-002 Parameter WASH_SECS, default 420, sets the WASH phase duration in seconds (10 bits).
REQ-003 Parameter DRAIN_SECS, default 480, sets the DRAIN phase duration in seconds (10 bits).
REQ-004 Parameter RINSE_SECS, default 240, sets the RINSE phase duration in seconds; it SHALL be used only under SEQ_RINSE_EN.
REQ-005 clk  in  1  system clock, 1 Hz tick domain, all logic on posedge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 go  in  1  start-cycle pulse; SHALL be honoured only in IDLE.
REQ-008 pause  in  1  level; freezes the countdown while high.
REQ-009 abort  in  1  pulse; terminates any cycle in progress.
REQ-010 tmr_done  in  1  countdown timer reached zero.
REQ-011 tmr_load  out  1  one-cycle strobe; timer loads tmr_secs.
REQ-012 tmr_secs  out  10  duration presented to the timer.
REQ-013 tmr_run  out  1  timer count enable.
REQ-014 phase  out  2  current phase: 0 FILL, 1 WASH, 2 DRAIN, 3 RINSE.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 cycle_done  out  1  one-cycle pulse at cycle completion.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, and every output SHALL be registered.
REQ-018 IDLE with go=1 and abort=0 SHALL move to LOAD with phase=0 on the next edge.
REQ-019 LOAD SHALL hold tmr_load=1 and tmr_secs=duration(phase) for exactly one cycle, then move to RUN.
REQ-020 RUN SHALL drive tmr_run = ~pause, and tmr_secs SHALL hold its value for the whole phase.
REQ-021 tmr_done SHALL be ignored in LOAD and sampled only in RUN, regardless of pause.
REQ-022 RUN with tmr_done=1 and a phase other than the last SHALL advance phase and return to LOAD.
REQ-023 RUN with tmr_done=1 in the last phase SHALL move to DONE.
REQ-024 Phase order SHALL be FILL, WASH, DRAIN, and the last phase SHALL be DRAIN.
REQ-025 DONE SHALL assert cycle_done for one cycle, clear phase to 0 and return to IDLE.
REQ-026 A zero-second duration SHALL complete its phase on the first RUN cycle (LOAD then RUN then advance, 2 cycles).
REQ-027 abort in any state other than IDLE SHALL move to IDLE on the next edge, clear phase, tmr_run and tmr_load, and SHALL NOT pulse cycle_done.
REQ-028 abort SHALL take priority over tmr_done and over go when they arrive in the same cycle.
REQ-029 go received while busy SHALL be ignored and SHALL NOT be queued.
REQ-030 pause held in IDLE, LOAD or DONE SHALL have no effect.

Reset
REQ-031 reset SHALL take priority over all inputs.
REQ-032 reset SHALL force state=IDLE, phase=0, tmr_load=0, tmr_run=0, tmr_secs=0, busy=0 and cycle_done=0.
REQ-033 reset asserted mid-phase SHALL abandon the cycle with no cycle_done pulse.

Configuration
REQ-034 With SEQ_RINSE_EN defined, the phase order SHALL be FILL, WASH, RINSE (phase=3, RINSE_SECS), DRAIN, and DRAIN SHALL remain the last phase.
REQ-035 Without SEQ_RINSE_EN, phase SHALL never equal 3 and RINSE_SECS SHALL have no effect.

Verification
REQ-036 Bench SHALL use a behavioural timer model with FILL_SECS=3, WASH_SECS=4, DRAIN_SECS=5: a go pulse -> tmr_load pulses with tmr_secs 3, 4, 5, phase steps 0, 1, 2, and cycle_done pulses once, 1 cycle after the DRAIN done.
REQ-037 pause high for 6 cycles during WASH -> tmr_run=0 for those 6 cycles and cycle_done delayed by exactly 6 cycles versus the REQ-036 run.
REQ-038 abort during DRAIN -> next cycle: busy=0, phase=0, tmr_run=0, and no cycle_done pulse.
REQ-039 abort and tmr_done in the same cycle during FILL -> IDLE; go in that same cycle, or at any point mid-cycle, is ignored.
REQ-040 FILL_SECS=0 -> FILL completes in 2 cycles, then tmr_load for WASH.
REQ-041 Build with SEQ_RINSE_EN, RINSE_SECS=2 -> phase order 0, 1, 3, 2 with tmr_secs 3, 4, 2, 5; reset asserted during RINSE -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/phase_sequencer.sv
// Cycle sequencer: steps FILL -> WASH -> DRAIN through an external countdown timer.
// Defining SEQ_RINSE_EN inserts a RINSE phase (phase=3) between WASH and DRAIN.
module phase_sequencer #(
  parameter int unsigned FILL_SECS  = 300,
  parameter int unsigned WASH_SECS  = 420,
  parameter int unsigned DRAIN_SECS = 480,
  parameter int unsigned RINSE_SECS = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       pause,
  input  logic       abort,
  input  logic       tmr_done,
  output logic       tmr_load,
  output logic [9:0] tmr_secs,
  output logic       tmr_run,
  output logic [1:0] phase,
  output logic       busy,
  output logic       cycle_done
);

  // state | meaning
  // IDLE  | waiting for go
  // LOAD  | tmr_load strobe with the current phase duration
  // RUN   | timer counting (unless paused), waiting for tmr_done
  // DONE  | cycle_done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [1:0] PH_FILL  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_DRAIN = 2'd2;
  localparam logic [1:0] PH_RINSE = 2'd3;

  localparam logic [9:0] FILL_D  = 10'(FILL_SECS);
  localparam logic [9:0] WASH_D  = 10'(WASH_SECS);
  localparam logic [9:0] DRAIN_D = 10'(DRAIN_SECS);
  localparam logic [9:0] RINSE_D = 10'(RINSE_SECS);

  state_t     state, state_nxt;
  logic [1:0] phase_nxt;
  logic [9:0] secs_nxt;
  logic       load_nxt, run_nxt, done_nxt;

  // Phase 3 is unreachable unless the rinse ordering below is compiled in.
  function automatic logic [9:0] duration(input logic [1:0] p);
    case (p)
      PH_FILL:  duration = FILL_D;
      PH_WASH:  duration = WASH_D;
      PH_DRAIN: duration = DRAIN_D;
      default:  duration = RINSE_D;
    endcase
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] p);
`ifdef SEQ_RINSE_EN
    case (p)
      PH_FILL:  next_phase = PH_WASH;
      PH_WASH:  next_phase = PH_RINSE;
      default:  next_phase = PH_DRAIN;
    endcase
`else
    case (p)
      PH_FILL:  next_phase = PH_WASH;
      default:  next_phase = PH_DRAIN;
    endcase
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    secs_nxt  = tmr_secs;
    load_nxt  = 1'b0;
    run_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (go && !abort) begin
          state_nxt = LOAD;
          phase_nxt = PH_FILL;
          secs_nxt  = duration(PH_FILL);
          load_nxt  = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = RUN;
        run_nxt   = 1'b1;
      end
      RUN: begin
        if (tmr_done) begin
          if (phase == PH_DRAIN) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOAD;
            phase_nxt = next_phase(phase);
            secs_nxt  = duration(next_phase(phase));
            load_nxt  = 1'b1;
          end
        end else begin
          run_nxt = ~pause;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        phase_nxt = PH_FILL;
      end
      default: state_nxt = IDLE;
    endcase
    // abort wins over tmr_done and go arriving in the same cycle
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      phase_nxt = PH_FILL;
      load_nxt  = 1'b0;
      run_nxt   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_FILL;
      tmr_secs   <= '0;
      tmr_load   <= 1'b0;
      tmr_run    <= 1'b0;
      cycle_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      tmr_secs   <= secs_nxt;
      tmr_load   <= load_nxt;
      tmr_run    <= run_nxt;
      cycle_done <= done_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: behavioural countdown timers, event-timing model derived
// from phase durations; a second instance covers the zero-second FILL case.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1, go = 1'b0, pause = 1'b0, abort = 1'b0;
  logic       tmr_done, tmr_load, tmr_run, busy, cycle_done;
  logic [9:0] tmr_secs;
  logic [1:0] phase;
  logic       z_tdone, z_load, z_run, z_busy, z_cdone;
  logic [9:0] z_secs;
  logic [1:0] z_phase;

  int checks = 0, errors = 0;
  int cyc = 0;
  int cnt = 0, zcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phase_sequencer #(.FILL_SECS(3), .WASH_SECS(4), .DRAIN_SECS(5), .RINSE_SECS(2)) dut (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .abort(abort), .tmr_done(tmr_done),
    .tmr_load(tmr_load), .tmr_secs(tmr_secs), .tmr_run(tmr_run), .phase(phase),
    .busy(busy), .cycle_done(cycle_done));

  phase_sequencer #(.FILL_SECS(0), .WASH_SECS(4), .DRAIN_SECS(5), .RINSE_SECS(2)) dut0 (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .abort(abort), .tmr_done(z_tdone),
    .tmr_load(z_load), .tmr_secs(z_secs), .tmr_run(z_run), .phase(z_phase),
    .busy(z_busy), .cycle_done(z_cdone));

  // countdown timers: load on strobe, count while enabled, done at zero
  always @(posedge clk) begin
    if (tmr_load) cnt <= int'(tmr_secs);
    else if (tmr_run && cnt > 0) cnt <= cnt - 1;
    if (z_load) zcnt <= int'(z_secs);
    else if (z_run && zcnt > 0) zcnt <= zcnt - 1;
  end
  assign tmr_done = (cnt == 0);
  assign z_tdone  = (zcnt == 0);

  int ph_list[$], secs_list[$];
  int e_cyc[$], e_ph[$], e_secs[$];
  int e_done;
  int o_cyc[$], o_ph[$], o_secs[$], o_done[$];
  int zo_cyc[$], zo_ph[$], zo_secs[$], zo_done[$];
  logic       s_busy[int], s_run[int], s_load[int], s_cdone[int], s_tdone[int];
  logic [1:0] s_phase[int];
  logic [9:0] s_secs[int];

  // Expected event times: each phase occupies LOAD + (secs+1) RUN cycles, plus any paused cycles.
  function automatic void model(input int l0, input int pk, input int pdel, input int s0);
    int t = l0;
    e_cyc.delete(); e_ph.delete(); e_secs.delete();
    for (int k = 0; k < ph_list.size(); k++) begin
      int d = (k == 0) ? s0 : secs_list[k];
      e_cyc.push_back(t); e_ph.push_back(ph_list[k]); e_secs.push_back(d);
      t += d + 2 + ((k == pk) ? pdel : 0);
    end
    e_done = t;
  endfunction

  task automatic run(input int ncyc, input int go_at, input int go2_at, input int pf,
                     input int pl, input int abort_at, input int reset_at);
    o_cyc.delete(); o_ph.delete(); o_secs.delete(); o_done.delete();
    zo_cyc.delete(); zo_ph.delete(); zo_secs.delete(); zo_done.delete();
    s_busy.delete(); s_run.delete(); s_load.delete(); s_cdone.delete();
    s_tdone.delete(); s_phase.delete(); s_secs.delete();
    for (int n = 0; n < ncyc; n++) begin
      int c;
      @(posedge clk); #1;
      c = cyc;
      go    = (c == go_at) || (c == go2_at);
      pause = (c >= pf) && (c < pf + pl);
      abort = (c == abort_at);
      reset = (c == reset_at);
      @(negedge clk);
      s_busy[c] = busy; s_run[c] = tmr_run; s_load[c] = tmr_load; s_cdone[c] = cycle_done;
      s_tdone[c] = tmr_done; s_phase[c] = phase; s_secs[c] = tmr_secs;
      if (tmr_load) begin o_cyc.push_back(c); o_ph.push_back(int'(phase)); o_secs.push_back(int'(tmr_secs)); end
      if (cycle_done) o_done.push_back(c);
      if (z_load) begin zo_cyc.push_back(c); zo_ph.push_back(int'(z_phase)); zo_secs.push_back(int'(z_secs)); end
      if (z_cdone) zo_done.push_back(c);
    end
    go = 1'b0; pause = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tmr_load !== 1'b0) begin errors++; $display("FAIL reset_tmr_load got %b exp 0", tmr_load); end
    checks++; if (tmr_secs !== 10'd0) begin errors++; $display("FAIL reset_tmr_secs got %0d exp 0", tmr_secs); end
    checks++; if (tmr_run !== 1'b0) begin errors++; $display("FAIL reset_tmr_run got %b exp 0", tmr_run); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_cycle_done got %b exp 0", cycle_done); end
    reset = 1'b0;
  endtask

  task automatic test_zero_fill();
    int g = cyc + 1 + $urandom_range(0, 3);
    run(40, g, -1, -1, 0, -1, -1);
    model(g + 1, -1, 0, 0);
    checks++;
    if (zo_cyc.size() != e_cyc.size()) begin
      errors++; $display("FAIL zero_nloads got %0d exp %0d", zo_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (zo_cyc[i] != e_cyc[i] || zo_ph[i] != e_ph[i] || zo_secs[i] != e_secs[i]) begin
          errors++; $display("FAIL zero_load%0d got cyc %0d ph %0d secs %0d exp cyc %0d ph %0d secs %0d",
                             i, zo_cyc[i], zo_ph[i], zo_secs[i], e_cyc[i], e_ph[i], e_secs[i]);
        end
      end
    end
    checks++;
    if (zo_done.size() != 1 || zo_done[0] != e_done) begin
      errors++; $display("FAIL zero_done got %0d pulses first %0d exp 1 at %0d",
                         zo_done.size(), (zo_done.size() > 0) ? zo_done[0] : -1, e_done);
    end
  endtask

  task automatic test_basic();
    for (int it = 0; it < 3; it++) begin
      int g = cyc + 1 + $urandom_range(0, 5);
      run(40, g, -1, -1, 0, -1, -1);
      model(g + 1, -1, 0, 3);
      checks++;
      if (o_cyc.size() != e_cyc.size()) begin
        errors++; $display("FAIL basic_nloads got %0d exp %0d", o_cyc.size(), e_cyc.size());
      end else begin
        for (int i = 0; i < e_cyc.size(); i++) begin
          checks++;
          if (o_cyc[i] != e_cyc[i] || o_ph[i] != e_ph[i] || o_secs[i] != e_secs[i]) begin
            errors++; $display("FAIL basic_load%0d got cyc %0d ph %0d secs %0d exp cyc %0d ph %0d secs %0d",
                               i, o_cyc[i], o_ph[i], o_secs[i], e_cyc[i], e_ph[i], e_secs[i]);
          end
        end
      end
      checks++;
      if (o_done.size() != 1 || o_done[0] != e_done) begin
        errors++; $display("FAIL basic_done got %0d pulses first %0d exp 1 at %0d",
                           o_done.size(), (o_done.size() > 0) ? o_done[0] : -1, e_done);
      end
      checks++;
      if (s_busy[e_done] !== 1'b1 || s_busy[e_done + 1] !== 1'b0 || s_phase[e_done + 1] !== 2'd0) begin
        errors++; $display("FAIL basic_return busy %b/%b phase %0d exp 1/0 phase 0",
                           s_busy[e_done], s_busy[e_done + 1], s_phase[e_done + 1]);
      end
    end
  endtask

  task automatic test_pause();
    for (int it = 0; it < 4; it++) begin
      int g = cyc + 1 + $urandom_range(0, 3);
      int last = ph_list.size() - 1;
      int k = (it == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 1 : last);
      int p = (it == 0) ? 6 : $urandom_range(1, 6);
      int s = $urandom_range(1, secs_list[k] - 1);
      int base, pf;
      logic low_ok = 1'b1;
      model(g + 1, -1, 0, 3);
      base = e_done;
      pf = e_cyc[k] + s;
      run(50, g, -1, pf, p, -1, -1);
      model(g + 1, k, p, 3);
      checks++;
      if (o_done.size() != 1 || o_done[0] != base + p) begin
        errors++; $display("FAIL pause_done_delay got %0d pulses at %0d exp 1 at %0d (pause %0d)",
                           o_done.size(), (o_done.size() > 0) ? o_done[0] : -1, base + p, p);
      end
      for (int c = pf + 1; c <= pf + p; c++) if (s_run[c] !== 1'b0) low_ok = 1'b0;
      checks++;
      if (!low_ok || s_run[pf + p + 1] !== 1'b1) begin
        errors++; $display("FAIL pause_tmr_run low_window_ok %b resume %b exp 1 1", low_ok, s_run[pf + p + 1]);
      end
      checks++;
      if (o_cyc.size() != e_cyc.size() || o_cyc[last] != e_cyc[last]) begin
        errors++; $display("FAIL pause_loads got %0d loads exp %0d, last at %0d",
                           o_cyc.size(), e_cyc.size(), e_cyc[last]);
      end
    end
  endtask

  task automatic test_pause_idle_load();
    int g = cyc + 3;
    int base;
    model(g + 1, -1, 0, 3);
    base = e_done;
    run(40, g, -1, cyc + 1, g + 1 - cyc, -1, -1);
    checks++;
    if (o_done.size() != 1 || o_done[0] != base || s_run[g + 2] !== 1'b1) begin
      errors++; $display("FAIL pause_idle_load done %0d pulses at %0d first_run %b exp 1 at %0d run 1",
                         o_done.size(), (o_done.size() > 0) ? o_done[0] : -1, s_run[g + 2], base);
    end
  endtask

  task automatic test_abort_drain();
    for (int it = 0; it < 2; it++) begin
      int g = cyc + 1 + $urandom_range(0, 3);
      int last = ph_list.size() - 1;
      int a;
      model(g + 1, -1, 0, 3);
      a = $urandom_range(e_cyc[last], e_done - 1);
      run(40, g, -1, -1, 0, a, -1);
      checks++;
      if (s_busy[a] !== 1'b1 || s_phase[a] !== 2'd2) begin
        errors++; $display("FAIL abort_pre busy %b phase %0d exp 1 phase 2", s_busy[a], s_phase[a]);
      end
      checks++;
      if (s_busy[a + 1] !== 1'b0 || s_phase[a + 1] !== 2'd0 || s_run[a + 1] !== 1'b0 || s_load[a + 1] !== 1'b0) begin
        errors++; $display("FAIL abort_next busy %b phase %0d run %b load %b exp all 0",
                           s_busy[a + 1], s_phase[a + 1], s_run[a + 1], s_load[a + 1]);
      end
      checks++;
      if (o_done.size() != 0 || o_cyc.size() != e_cyc.size()) begin
        errors++; $display("FAIL abort_no_done got %0d pulses %0d loads exp 0 pulses %0d loads",
                           o_done.size(), o_cyc.size(), e_cyc.size());
      end
    end
  endtask

  task automatic test_abort_tmr_done();
    int g = cyc + 2;
    int a = g + 5;
    run(40, g, a, -1, 0, a, -1);
    checks++;
    if (s_tdone[a] !== 1'b1 || s_phase[a] !== 2'd0 || s_busy[a] !== 1'b1) begin
      errors++; $display("FAIL abort_coinc_setup tmr_done %b phase %0d busy %b exp 1 0 1",
                         s_tdone[a], s_phase[a], s_busy[a]);
    end
    checks++;
    if (s_busy[a + 1] !== 1'b0 || s_busy[a + 10] !== 1'b0 || o_cyc.size() != 1 || o_done.size() != 0) begin
      errors++; $display("FAIL abort_coinc busy %b/%b loads %0d done %0d exp 0/0 1 0",
                         s_busy[a + 1], s_busy[a + 10], o_cyc.size(), o_done.size());
    end
    g = cyc + 2;
    run(10, g, -1, -1, 0, g, -1);
    checks++;
    if (s_busy[g + 1] !== 1'b0 || o_cyc.size() != 0) begin
      errors++; $display("FAIL abort_go_idle busy %b loads %0d exp 0 0", s_busy[g + 1], o_cyc.size());
    end
  endtask

  task automatic test_go_ignored();
    for (int it = 0; it < 3; it++) begin
      int g = cyc + 1 + $urandom_range(0, 3);
      int g2;
      model(g + 1, -1, 0, 3);
      g2 = $urandom_range(g + 1, e_done);
      run(45, g, g2, -1, 0, -1, -1);
      checks++;
      if (o_cyc.size() != e_cyc.size() || o_done.size() != 1 || o_done[0] != e_done) begin
        errors++; $display("FAIL go_ignored loads %0d done %0d exp %0d loads done at %0d (go2 %0d)",
                           o_cyc.size(), o_done.size(), e_cyc.size(), e_done, g2);
      end
      checks++;
      if (s_busy[e_done + 1] !== 1'b0 || s_busy[e_done + 5] !== 1'b0) begin
        errors++; $display("FAIL go_not_queued busy %b/%b exp 0/0", s_busy[e_done + 1], s_busy[e_done + 5]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g = cyc + 2;
    int k = ph_list.size() - 2;
    int r;
    model(g + 1, -1, 0, 3);
    r = $urandom_range(e_cyc[k] + 1, e_cyc[k + 1] - 1);
    run(40, g, -1, -1, 0, -1, r);
    checks++;
    if (s_phase[r] !== 2'(ph_list[k]) || s_busy[r] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_setup phase %0d busy %b exp %0d 1", s_phase[r], s_busy[r], ph_list[k]);
    end
    checks++;
    if (s_busy[r + 1] !== 1'b0 || s_phase[r + 1] !== 2'd0 || s_run[r + 1] !== 1'b0 ||
        s_load[r + 1] !== 1'b0 || s_secs[r + 1] !== 10'd0 || s_cdone[r + 1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs busy %b phase %0d run %b load %b secs %0d cdone %b exp all 0",
                         s_busy[r + 1], s_phase[r + 1], s_run[r + 1], s_load[r + 1], s_secs[r + 1], s_cdone[r + 1]);
    end
    checks++;
    if (o_done.size() != 0) begin
      errors++; $display("FAIL reset_mid_no_done got %0d pulses exp 0", o_done.size());
    end
  endtask

  initial begin
`ifdef SEQ_RINSE_EN
    ph_list = '{0, 1, 3, 2}; secs_list = '{3, 4, 2, 5};
`else
    ph_list = '{0, 1, 2}; secs_list = '{3, 4, 5};
`endif
    test_reset();
    test_zero_fill();
    test_basic();
    test_pause();
    test_pause_idle_load();
    test_abort_drain();
    test_abort_tmr_done();
    test_go_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
